// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, default timing constants and
// a small saturating counter helper used by the game flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_MENU    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_WON     = 2'd2,
        ST_LOST    = 2'd3
    } game_state_t;

    localparam int WIN_TIME_DEFAULT      = 200;
    localparam int LIVES_INIT_DEFAULT    = 3;
    localparam int INVULN_CYCLES_DEFAULT = 30;
    localparam int RESULT_HOLD_DEFAULT   = 60;

    // Width of the hold and invulnerability down-counters.
    localparam int CNT_W = 16;

    // Increment a 4-bit count, sticking at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of the game controller's inputs (buttons, renderer, shape counter)
// and its status outputs. The controller takes the slave side.
interface game_flow_ctrl_if;

    logic        start_btn;
    logic        quit_btn;
    logic        collision;
    logic [10:0] game_time;
    logic        menu_screen;
    logic        player_won;
    logic        player_lost;
    logic [1:0]  lives;
    logic        invulnerable;
    logic [3:0]  win_count;

    modport master (
        output start_btn, quit_btn, collision, game_time,
        input  menu_screen, player_won, player_lost, lives, invulnerable, win_count
    );

    modport slave (
        input  start_btn, quit_btn, collision, game_time,
        output menu_screen, player_won, player_lost, lives, invulnerable, win_count
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw push-button.
// A press yields one pulse, visible two edges after the raw rise so the
// consumer acts on the third edge. The valid shift register masks the
// pulse until the edge flop holds real button data, so a button already
// held when reset releases never produces a pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [2:0] vld;

    // Synchronize the raw button and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            vld   <= 3'b000;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            vld   <= {vld[1:0], 1'b1};
        end
    end

    assign pulse = sync2 & ~prev & vld[2];

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: MENU -> PLAYING -> WON/LOST -> MENU, tracking lives,
// a post-hit invulnerability window and a saturating count of levels won.
// All status outputs come straight from flops.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int WIN_TIME      = WIN_TIME_DEFAULT,
    parameter int LIVES_INIT    = LIVES_INIT_DEFAULT,
    parameter int INVULN_CYCLES = INVULN_CYCLES_DEFAULT,
    parameter int RESULT_HOLD   = RESULT_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    game_flow_ctrl_if.slave  bus
);

    localparam logic [10:0]      WIN_VAL   = 11'(WIN_TIME);
    localparam logic [1:0]       LIVES_VAL = 2'(LIVES_INIT);
    localparam logic [CNT_W-1:0] INV_LOAD  = CNT_W'(INVULN_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESULT_HOLD - 1);

    game_state_t      state;
    game_state_t      state_n;
    logic [1:0]       lives_q;
    logic [1:0]       lives_n;
    logic [3:0]       wins_q;
    logic [3:0]       wins_n;
    logic [CNT_W-1:0] inv_q;
    logic [CNT_W-1:0] inv_n;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_n;

    logic menu_q;
    logic won_q;
    logic lost_q;
    logic invul_q;
    logic menu_n;
    logic won_n;
    logic lost_n;
    logic invul_n;

    logic start_p;
    logic quit_p;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.start_btn),
        .pulse (start_p)
    );

    btn_sync_edge u_quit_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.quit_btn),
        .pulse (quit_p)
    );

    // State register together with lives, win count and both down-counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_MENU;
            lives_q <= LIVES_VAL;
            wins_q  <= 4'd0;
            inv_q   <= '0;
            hold_q  <= '0;
        end else begin
            state   <= state_n;
            lives_q <= lives_n;
            wins_q  <= wins_n;
            inv_q   <= inv_n;
            hold_q  <= hold_n;
        end
    end

    // Next-state logic; in PLAYING quit beats win, win beats collision.
    always_comb begin
        state_n = state;
        lives_n = lives_q;
        wins_n  = wins_q;
        inv_n   = inv_q;
        hold_n  = hold_q;
        case (state)
            ST_MENU: begin
                if (start_p) begin
                    state_n = ST_PLAYING;
                    lives_n = LIVES_VAL;
                    inv_n   = '0;
                end
            end
            ST_PLAYING: begin
                if (inv_q != '0) begin
                    inv_n = inv_q - 1'b1;
                end
                if (quit_p) begin
                    state_n = ST_MENU;
                end else if (bus.game_time == WIN_VAL) begin
                    state_n = ST_WON;
                    hold_n  = HOLD_LOAD;
                    wins_n  = sat_inc4(wins_q);
                end else if (bus.collision && (inv_q == '0)) begin
                    if (lives_q > 2'd1) begin
                        lives_n = lives_q - 2'd1;
                        inv_n   = INV_LOAD;
                    end else begin
                        lives_n = 2'd0;
                        state_n = ST_LOST;
                        hold_n  = HOLD_LOAD;
                    end
                end
            end
            ST_WON, ST_LOST: begin
                if (hold_q == '0) begin
                    state_n = ST_MENU;
                end else begin
                    hold_n = hold_q - 1'b1;
                end
            end
            default: begin
                state_n = ST_MENU;
            end
        endcase
    end

    // Decode the upcoming state into next values for the registered outputs.
    always_comb begin
        menu_n  = (state_n == ST_MENU);
        won_n   = (state_n == ST_WON);
        lost_n  = (state_n == ST_LOST);
        invul_n = (inv_n != '0);
    end

    // Output register so every status line is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            menu_q  <= 1'b1;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            invul_q <= 1'b0;
        end else begin
            menu_q  <= menu_n;
            won_q   <= won_n;
            lost_q  <= lost_n;
            invul_q <= invul_n;
        end
    end

    assign bus.menu_screen  = menu_q;
    assign bus.player_won   = won_q;
    assign bus.player_lost  = lost_q;
    assign bus.invulnerable = invul_q;
    assign bus.lives        = lives_q;
    assign bus.win_count    = wins_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl with hand-computed expectations.
module tb_game_flow_ctrl;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;
    int   exp_wins;

    game_flow_ctrl_if bus ();

    game_flow_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic q, input logic c, input logic [10:0] gt);
        bus.start_btn = s;
        bus.quit_btn  = q;
        bus.collision = c;
        bus.game_time = gt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic menu, input logic won, input logic lost,
                               input logic [1:0] lv, input logic inv, input logic [3:0] wc);
        chk({tag, ".menu_screen"},  32'(bus.menu_screen),  32'(menu));
        chk({tag, ".player_won"},   32'(bus.player_won),   32'(won));
        chk({tag, ".player_lost"},  32'(bus.player_lost),  32'(lost));
        chk({tag, ".lives"},        32'(bus.lives),        32'(lv));
        chk({tag, ".invulnerable"}, 32'(bus.invulnerable), 32'(inv));
        chk({tag, ".win_count"},    32'(bus.win_count),    32'(wc));
    endtask

    // Press start, release after the third edge, expect a fresh game.
    task automatic startGame(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0);
        tick(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'(exp_wins));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        exp_wins     = 0;

        // Reset with start held, then release: no game may start.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0);
        tick(2);
        checkOutput("reset", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        reset = 1'b0;
        tick(6);
        checkOutput("held_start", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);

        // Release and press again: PLAYING on the third edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0);
        tick(2);
        checkOutput("start_lat2", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        tick(1);
        checkOutput("start_lat3", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);

        // game_time ramp to 200 wins the level.
        for (int g = 0; g < 200; g++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 11'(g));
            tick(1);
        end
        checkOutput("ramp_199", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd200);
        tick(1);
        exp_wins = 1;
        checkOutput("won_entry", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(59);
        checkOutput("won_hold_last", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'd1);
        tick(1);
        checkOutput("won_to_menu", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd1);

        // Collision held: lives 3->2, 31 cycles later 2->1, 31 more -> LOST.
        startGame("start_coll");
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd0);
        tick(1);
        checkOutput("hit1", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'd1);
        tick(30);
        checkOutput("invuln_expired", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'd1);
        tick(1);
        checkOutput("hit2", 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'd1);
        tick(30);
        checkOutput("before_hit3", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1);
        tick(1);
        checkOutput("hit3_lost", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1);
        tick(7);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(52);
        checkOutput("lost_hold_last", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1);
        tick(1);
        checkOutput("lost_to_menu", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd1);

        // Quit in MENU is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 11'd0);
        tick(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        checkOutput("quit_in_menu", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd1);

        // Quit, win and collision on the same edge: quit wins.
        startGame("start_quit");
        applyStimulus(1'b0, 1'b1, 1'b0, 11'd0);
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd200);
        tick(1);
        checkOutput("quit_priority", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);

        // Bring lives to 1, check >WIN_TIME is no win, then win beats collision.
        startGame("start_last_life");
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd0);
        tick(1);
        checkOutput("ll_hit1", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(30);
        checkOutput("ll_expired", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd0);
        tick(1);
        checkOutput("ll_hit2", 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd201);
        tick(30);
        checkOutput("above_win_time", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd200);
        tick(1);
        exp_wins = 2;
        checkOutput("win_over_collision", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 4'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(60);
        checkOutput("ll_to_menu", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'd2);

        // Fourteen more wins push the count past 15; it must stick there.
        for (int i = 0; i < 14; i++) begin
            startGame("start_loop");
            applyStimulus(1'b0, 1'b0, 1'b0, 11'd200);
            tick(1);
            if (exp_wins < 15) exp_wins++;
            checkOutput("win_loop", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'(exp_wins));
            applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
            tick(60);
        end
        checkOutput("saturated_menu", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd15);

        // Reset during WON hold acts at once; start held across release is ignored.
        startGame("start_final");
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd200);
        tick(1);
        checkOutput("final_win", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'd15);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);
        tick(10);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0);
        #1;
        exp_wins = 0;
        checkOutput("reset_mid_hold", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        checkOutput("reset_release_held", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter WIN_TIME, default 200: game_time value at which the level is won.
REQ-002 Parameter LIVES_INIT, default 3: lives loaded on entry to PLAYING.
REQ-003 Parameter INVULN_CYCLES, default 30: collision-ignore window after a life is lost.
REQ-004 Parameter RESULT_HOLD, default 60: cycles that WON/LOST is held before returning to MENU.
REQ-005 clk  input  1  game clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start_btn  input  1  raw, asynchronous start push-button, active-high.
REQ-008 quit_btn  input  1  raw, asynchronous quit push-button, active-high.
REQ-009 collision  input  1  synchronous level from the renderer, high while player overlaps an obstacle.
REQ-010 game_time  input  11  level-progress count from the shape counter; it is zero while any of this block's status outputs is high.
REQ-011 menu_screen  output  1  high in MENU.
REQ-012 player_won  output  1  high in WON.
REQ-013 player_lost  output  1  high in LOST.
REQ-014 lives  output  2  remaining lives.
REQ-015 invulnerable  output  1  high while the invulnerability counter is nonzero.
REQ-016 win_count  output  4  number of levels won since reset, saturating.

Function
REQ-017 The FSM states SHALL be MENU, PLAYING, WON and LOST, and every output SHALL be registered (Moore).
REQ-018 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector, giving one one-cycle pulse per press, 3 cycles after the raw rise.
REQ-019 In MENU, a start pulse SHALL move the FSM to PLAYING, load lives=LIVES_INIT, and clear the invulnerability counter. A quit pulse SHALL be ignored.
REQ-020 In PLAYING, priority SHALL be quit > win > collision, with at most one event acted on per cycle.
REQ-021 Quit: a quit pulse in PLAYING SHALL move the FSM to MENU on the same edge, with lives unchanged.
REQ-022 Win: game_time == WIN_TIME in PLAYING SHALL move the FSM to WON, load the hold counter with RESULT_HOLD-1, and increment win_count (saturating at 15).
REQ-023 Collision with invulnerable low and lives > 1 SHALL decrement lives and load the invulnerability counter with INVULN_CYCLES; the FSM stays in PLAYING.
REQ-024 Collision with invulnerable low and lives == 1 SHALL set lives to 0, move the FSM to LOST, and load the hold counter with RESULT_HOLD-1.
REQ-025 Collision with invulnerable high SHALL have no effect. The invulnerability counter SHALL decrement by 1 per cycle down to 0, and only in PLAYING.
REQ-026 A collision that stays high SHALL cost at most one life per invulnerability window. A new life is lost on the first cycle the counter reads 0 with collision still high.
REQ-027 In WON/LOST, the hold counter SHALL decrement each cycle and the FSM SHALL go to MENU on the edge where it reads 0. Both button pulses SHALL be ignored.
REQ-028 Exactly one of menu_screen, player_won, player_lost SHALL be high, except in PLAYING, where all three are low.
REQ-029 game_time values above WIN_TIME SHALL be treated as no-win; only equality triggers WON.

Reset
REQ-030 Reset SHALL force: state=MENU, menu_screen=1, player_won=0, player_lost=0, lives=LIVES_INIT, invulnerable=0, win_count=0, hold and invulnerability counters=0, and synchronizer/edge flops=0.
REQ-031 Reset asserted mid-game or mid-hold SHALL take effect immediately, with no pulse generated on release even if a button is held.

Structure
REQ-032 Package game_pkg SHALL hold the state enum and the default constants for WIN_TIME, LIVES_INIT, INVULN_CYCLES and RESULT_HOLD, shared with the shape counter and renderer.
REQ-033 Sub-module btn_sync_edge (synchronizer plus rising-edge pulse) SHALL be instantiated once per button.

Verification
REQ-034 Reset release with start_btn held high: no PLAYING entry. Release the button and press again: PLAYING exactly 3 cycles after the raw rise, with lives=3.
REQ-035 PLAYING, no collisions, game_time ramps 0..200: player_won=1 on the cycle after game_time=200, held 60 cycles, then menu_screen=1 and win_count=1.
REQ-036 Collision held high for 70 cycles: lives 3->2 at the first edge, 2->1 at 31 cycles later, 1->0 at 62 cycles later (LOST), then player_lost held 60 cycles.
REQ-037 Same cycle quit pulse, game_time=200 and collision: MENU, win_count and lives unchanged. Same cycle game_time=200 and collision with lives=1: WON, lives=1.
REQ-038 Sixteen consecutive wins: win_count saturates at 15. Reset asserted during WON hold: immediate MENU with all outputs at reset values.
